// File: rtl/mode_seq_pkg.sv
// Shared types and constants for the mode step sequencer.
// Holds the state encoding and the mode to terminal-count table.
package mode_seq_pkg;

    localparam int MODE_W = 3;
    localparam int CNT_W  = 5;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        RUN,
        DONE
    } state_t;

    // Terminal count per mode; unlisted modes run zero steps.
    function automatic logic [CNT_W-1:0] mode_to_max_num(
        input logic [MODE_W-1:0] mode
    );
        logic [CNT_W-1:0] n;
        case (mode)
            3'd1:    n = 5'd6;
            3'd3:    n = 5'd11;
            3'd4:    n = 5'd6;
            3'd5:    n = 5'd16;
            default: n = 5'd0;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/mode_step_sequencer_step_counter.sv
// Step counter with clear, enable and a terminal-reached flag.
// last is only meaningful for a non-zero terminal value.
module step_counter
    import mode_seq_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             enable,
    input  logic [CNT_W-1:0] terminal,
    output logic [CNT_W-1:0] count,
    output logic             last
);

    assign last = (terminal != '0) &&
                  (count == terminal - CNT_W'(1));

    // Count register: clear wins over enable.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable) begin
            count <= count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/mode_step_sequencer.sv
// Accepts a mode, runs a tick-driven step count to its terminal
// value and pulses done; optional auto-repeat of the same mode.
module mode_step_sequencer
    import mode_seq_pkg::*;
#(
    parameter int AUTO_REPEAT = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [MODE_W-1:0] mode_in,
    input  logic              mode_valid,
    output logic              mode_ready,
    input  logic              tick,
    input  logic              abort,
    output logic [MODE_W-1:0] cur_mode,
    output logic [CNT_W-1:0]  max_num,
    output logic [CNT_W-1:0]  count,
    output logic              busy,
    output logic              done
);

    state_t state;
    state_t nxt;
    logic   cnt_clear;
    logic   cnt_en;
    logic   latch;
    logic   last;

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= nxt;
        end
    end

    // Next state and counter controls; abort overrides everything.
    always_comb begin
        nxt       = state;
        cnt_clear = 1'b0;
        cnt_en    = 1'b0;
        latch     = 1'b0;
        if (abort) begin
            nxt       = IDLE;
            cnt_clear = 1'b1;
        end else begin
            unique case (state)
                IDLE: begin
                    if (mode_valid) begin
                        nxt   = LOAD;
                        latch = 1'b1;
                    end
                end
                LOAD: begin
                    cnt_clear = 1'b1;
                    nxt = (max_num == '0) ? DONE : RUN;
                end
                RUN: begin
                    if (tick) begin
                        if (last) begin
                            nxt = DONE;
                        end else begin
                            cnt_en = 1'b1;
                        end
                    end
                end
                DONE: begin
                    nxt = (AUTO_REPEAT != 0) ? LOAD : IDLE;
                end
                default: nxt = IDLE;
            endcase
        end
    end

    // Mode and its terminal count are captured on accept only.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cur_mode <= '0;
            max_num  <= '0;
        end else if (latch) begin
            cur_mode <= mode_in;
            max_num  <= mode_to_max_num(mode_in);
        end
    end

    step_counter u_cnt (
        .clk      (clk),
        .rst_n    (rst_n),
        .clear    (cnt_clear),
        .enable   (cnt_en),
        .terminal (max_num),
        .count    (count),
        .last     (last)
    );

    assign mode_ready = (state == IDLE);
    assign busy       = (state == LOAD) || (state == RUN);
    assign done       = (state == DONE);

endmodule

// File: tb/tb_mode_step_sequencer.sv
// Bench for mode_step_sequencer: vector table, directed corner
// sequences and random stimulus against a behavioural model.
module tb_mode_step_sequencer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n      = 1'b0;
    logic       mode_valid = 1'b0;
    logic       tick       = 1'b0;
    logic       abort      = 1'b0;
    logic [2:0] mode_in    = 3'd0;

    logic       ready0, busy0, done0;
    logic       ready1, busy1, done1;
    logic [2:0] cm0, cm1;
    logic [4:0] mx0, mx1, cnt0, cnt1;

    mode_step_sequencer #(.AUTO_REPEAT(0)) u0 (
        .clk        (clk),
        .rst_n      (rst_n),
        .mode_in    (mode_in),
        .mode_valid (mode_valid),
        .mode_ready (ready0),
        .tick       (tick),
        .abort      (abort),
        .cur_mode   (cm0),
        .max_num    (mx0),
        .count      (cnt0),
        .busy       (busy0),
        .done       (done0)
    );

    mode_step_sequencer #(.AUTO_REPEAT(1)) u1 (
        .clk        (clk),
        .rst_n      (rst_n),
        .mode_in    (mode_in),
        .mode_valid (mode_valid),
        .mode_ready (ready1),
        .tick       (tick),
        .abort      (abort),
        .cur_mode   (cm1),
        .max_num    (mx1),
        .count      (cnt1),
        .busy       (busy1),
        .done       (done1)
    );

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    // Reference model: phase 0 idle, 1 load, 2 run, 3 done.
    int ph[2];
    int md[2];
    int mx[2];
    int ct[2];
    int mtab[8] = '{0, 6, 0, 11, 6, 16, 0, 0};

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)",
                     nm, act, exp, cyc);
        end
    endtask

    task automatic model_step(input int k);
        if (!rst_n) begin
            ph[k] = 0; ct[k] = 0; md[k] = 0; mx[k] = 0;
        end else if (abort) begin
            ph[k] = 0; ct[k] = 0;
        end else begin
            case (ph[k])
                0: if (mode_valid) begin
                    md[k] = int'(mode_in);
                    mx[k] = mtab[mode_in];
                    ph[k] = 1;
                end
                1: begin
                    ct[k] = 0;
                    ph[k] = (mx[k] == 0) ? 3 : 2;
                end
                2: if (tick) begin
                    if (ct[k] + 1 == mx[k]) ph[k] = 3;
                    else ct[k] = ct[k] + 1;
                end
                default: ph[k] = (k == 1) ? 1 : 0;
            endcase
        end
    endtask

    task automatic cmp_one(input string tg, input int k,
                           input logic r, input logic b,
                           input logic d, input logic [2:0] c,
                           input logic [4:0] m,
                           input logic [4:0] n);
        chk({tg, ".ready"}, 32'(r), 32'(ph[k] == 0));
        chk({tg, ".busy"}, 32'(b),
            32'(ph[k] == 1 || ph[k] == 2));
        chk({tg, ".done"}, 32'(d), 32'(ph[k] == 3));
        chk({tg, ".cur_mode"}, 32'(c), md[k]);
        chk({tg, ".max_num"}, 32'(m), mx[k]);
        chk({tg, ".count"}, 32'(n), ct[k]);
    endtask

    task automatic cycle();
        for (int k = 0; k < 2; k++) model_step(k);
        @(posedge clk);
        #1;
        cyc++;
        cmp_one("d0", 0, ready0, busy0, done0, cm0, mx0, cnt0);
        cmp_one("d1", 1, ready1, busy1, done1, cm1, mx1, cnt1);
    endtask

    task automatic idle_both();
        mode_valid = 1'b0;
        tick = 1'b0;
        abort = 1'b1;
        cycle();
        abort = 1'b0;
    endtask

    typedef struct {
        logic       v;
        logic [2:0] m;
        logic       t;
        logic       a;
        logic [4:0] e_cnt;
        logic       e_done;
        logic       e_ready;
        logic       e_busy;
        logic [2:0] e_cm;
        logic [4:0] e_mx;
    } vec_t;

    vec_t tv[19];

    task automatic setv(input int i, input int v, input int m,
                        input int t, input int a, input int ec,
                        input int ed, input int er, input int eb,
                        input int ecm, input int emx);
        tv[i].v       = 1'(v);
        tv[i].m       = 3'(m);
        tv[i].t       = 1'(t);
        tv[i].a       = 1'(a);
        tv[i].e_cnt   = 5'(ec);
        tv[i].e_done  = 1'(ed);
        tv[i].e_ready = 1'(er);
        tv[i].e_busy  = 1'(eb);
        tv[i].e_cm    = 3'(ecm);
        tv[i].e_mx    = 5'(emx);
    endtask

    initial begin
        int last_done;
        int pulses;
        int peak;
        int seen;
        int cat;

        // v m t a | cnt done ready busy cm mx
        setv(0,  1, 1, 1, 0,  0, 0, 0, 1, 1, 6);
        setv(1,  0, 0, 1, 0,  0, 0, 0, 1, 1, 6);
        setv(2,  0, 0, 1, 0,  1, 0, 0, 1, 1, 6);
        setv(3,  0, 0, 1, 0,  2, 0, 0, 1, 1, 6);
        setv(4,  0, 0, 1, 0,  3, 0, 0, 1, 1, 6);
        setv(5,  0, 0, 1, 0,  4, 0, 0, 1, 1, 6);
        setv(6,  0, 0, 1, 0,  5, 0, 0, 1, 1, 6);
        setv(7,  0, 0, 1, 0,  5, 1, 0, 0, 1, 6);
        setv(8,  0, 0, 1, 0,  5, 0, 1, 0, 1, 6);
        setv(9,  1, 3, 1, 1,  0, 0, 1, 0, 1, 6);
        setv(10, 1, 2, 0, 0,  0, 0, 0, 1, 2, 0);
        setv(11, 0, 0, 0, 0,  0, 1, 0, 0, 2, 0);
        setv(12, 0, 0, 0, 0,  0, 0, 1, 0, 2, 0);
        setv(13, 1, 7, 0, 0,  0, 0, 0, 1, 7, 0);
        setv(14, 0, 0, 0, 0,  0, 1, 0, 0, 7, 0);
        setv(15, 0, 0, 0, 0,  0, 0, 1, 0, 7, 0);
        setv(16, 1, 6, 0, 0,  0, 0, 0, 1, 6, 0);
        setv(17, 0, 0, 0, 0,  0, 1, 0, 0, 6, 0);
        setv(18, 0, 0, 0, 0,  0, 0, 1, 0, 6, 0);

        rst_n = 1'b0;
        cycle();
        cycle();
        rst_n = 1'b1;

        for (int i = 0; i < 19; i++) begin
            mode_valid = tv[i].v;
            mode_in    = tv[i].m;
            tick       = tv[i].t;
            abort      = tv[i].a;
            cycle();
            chk("tv.count", 32'(cnt0), 32'(tv[i].e_cnt));
            chk("tv.done", 32'(done0), 32'(tv[i].e_done));
            chk("tv.ready", 32'(ready0), 32'(tv[i].e_ready));
            chk("tv.busy", 32'(busy0), 32'(tv[i].e_busy));
            chk("tv.cur_mode", 32'(cm0), 32'(tv[i].e_cm));
            chk("tv.max_num", 32'(mx0), 32'(tv[i].e_mx));
        end

        // Mode 5 stepping on every third cycle.
        idle_both();
        mode_valid = 1'b1;
        mode_in = 3'd5;
        cycle();
        mode_valid = 1'b0;
        peak = 0;
        seen = 0;
        cat = 0;
        for (int i = 0; i < 200 && seen == 0; i++) begin
            tick = (i % 3 == 2);
            cycle();
            if (int'(cnt0) > peak) peak = int'(cnt0);
            if (done0) begin
                seen = 1;
                cat = int'(cnt0);
            end
        end
        chk("m5.done_seen", 32'(seen), 1);
        chk("m5.count_at_done", 32'(cat), 15);
        chk("m5.peak", 32'(peak), 15);

        // Mode 3 aborted together with a tick at count 10.
        idle_both();
        mode_valid = 1'b1;
        mode_in = 3'd3;
        tick = 1'b1;
        cycle();
        mode_valid = 1'b0;
        seen = 0;
        for (int i = 0; i < 40 && seen == 0; i++) begin
            if (ph[0] == 2 && ct[0] == 10) seen = 1;
            else cycle();
        end
        chk("ab.reached10", 32'(seen), 1);
        abort = 1'b1;
        cycle();
        abort = 1'b0;
        chk("ab.ready", 32'(ready0), 1);
        chk("ab.count", 32'(cnt0), 0);
        chk("ab.done", 32'(done0), 0);
        chk("ab.cur_mode", 32'(cm0), 3);
        cycle();
        chk("ab.no_done_after", 32'(done0), 0);

        // Mode 3 interrupted by reset at count 4.
        idle_both();
        mode_valid = 1'b1;
        mode_in = 3'd3;
        tick = 1'b1;
        cycle();
        mode_valid = 1'b0;
        seen = 0;
        for (int i = 0; i < 40 && seen == 0; i++) begin
            if (ph[0] == 2 && ct[0] == 4) seen = 1;
            else cycle();
        end
        chk("rst.reached4", 32'(seen), 1);
        rst_n = 1'b0;
        cycle();
        rst_n = 1'b1;
        tick = 1'b0;
        chk("rst.count", 32'(cnt0), 0);
        chk("rst.cur_mode", 32'(cm0), 0);
        chk("rst.max_num", 32'(mx0), 0);
        chk("rst.busy", 32'(busy0), 0);
        chk("rst.done", 32'(done0), 0);
        chk("rst.ready", 32'(ready0), 1);
        cycle();
        chk("rst.no_done_after", 32'(done0), 0);

        // Auto-repeat on mode 4 with stray mode_valid during RUN.
        idle_both();
        mode_valid = 1'b1;
        mode_in = 3'd4;
        tick = 1'b1;
        cycle();
        last_done = -1;
        pulses = 0;
        for (int i = 0; i < 60; i++) begin
            mode_valid = (i % 5 == 3);
            mode_in = 3'd2;
            cycle();
            if (done1) begin
                if (last_done >= 0)
                    chk("ar.period", 32'(cyc - last_done), 8);
                last_done = cyc;
                pulses++;
            end
        end
        chk("ar.pulses", 32'(pulses >= 6), 1);
        chk("ar.cur_mode", 32'(cm1), 4);
        mode_valid = 1'b0;

        // Random stimulus checked against the model.
        for (int i = 0; i < 1500; i++) begin
            rst_n      = ($urandom_range(0, 99) != 0);
            abort      = ($urandom_range(0, 24) == 0);
            mode_valid = ($urandom_range(0, 2) == 0);
            tick       = ($urandom_range(0, 1) == 0);
            mode_in    = 3'($urandom_range(0, 7));
            cycle();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
